lcd_win_ctrl: RTL and testbench

Parametrised image-window display controller, successor to the fixed 6x6/3x3 LCD controller. Loads an IMG_W x IMG_H image serially into an internal buffer, keeps a movable WIN x WIN window and streams the window contents one pixel per cycle. Adds parametrised image and window size, and horizontal/vertical mirror modes. Sits between the host command interface and the LCD panel driver.

---
 rtl/lcd_win_pkg.sv | 28 ++
 rtl/lcd_win_addr.sv | 33 +++
 rtl/lcd_win_ctrl.sv | 135 +++++++++++++
 tb/tb_lcd_win_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_win_pkg.sv
// Shared types and width helper for the LCD image-window controller.
// Command codes and FSM states live here so the bench and the RTL agree on them.
package lcd_win_pkg;

  typedef enum logic [2:0] {
    CMD_REFRESH  = 3'd0,
    CMD_LOAD     = 3'd1,
    CMD_RIGHT    = 3'd2,
    CMD_LEFT     = 3'd3,
    CMD_UP       = 3'd4,
    CMD_DOWN     = 3'd5,
    CMD_MIRROR_H = 3'd6,
    CMD_MIRROR_V = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    OUT  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lcd_win_addr.sv
// Combinational buffer index for the window pixel at (row, col), honouring
// the window origin and the horizontal/vertical mirror flags.
module lcd_win_addr
  import lcd_win_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int WIN   = 3,
  parameter int OXW   = width_of(IMG_W - WIN + 1),
  parameter int OYW   = width_of(IMG_H - WIN + 1),
  parameter int CW    = width_of(WIN),
  parameter int AW    = width_of(IMG_W * IMG_H)
) (
  input  logic [OXW-1:0] ox,
  input  logic [OYW-1:0] oy,
  input  logic [CW-1:0]  row,
  input  logic [CW-1:0]  col,
  input  logic           mirror_h,
  input  logic           mirror_v,
  output logic [AW-1:0]  idx
);

  logic [AW-1:0] src_col;
  logic [AW-1:0] src_row;

  // All terms stay below IMG_W*IMG_H, so AW-bit unsigned arithmetic never wraps.
  always_comb begin
    src_col = AW'(ox) + (mirror_h ? (AW'(WIN - 1) - AW'(col)) : AW'(col));
    src_row = AW'(oy) + (mirror_v ? (AW'(WIN - 1) - AW'(row)) : AW'(row));
    idx     = src_row * AW'(IMG_W) + src_col;
  end

endmodule

// File: rtl/lcd_win_ctrl.sv
// Image-window display controller: serial image load, movable/mirrorable
// WIN x WIN window, one window pixel streamed per cycle.
//
// state | meaning
// IDLE  | waiting for a command, busy low
// LOAD  | sampling IMG_W*IMG_H pixels from datain in raster order
// OUT   | registering one window pixel per cycle into dataout
// DONE  | drops output_valid and busy, returns to IDLE
module lcd_win_ctrl
  import lcd_win_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int WIN    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] datain,
  input  logic [2:0]        cmd,
  input  logic              cmd_valid,
  output logic [DATA_W-1:0] dataout,
  output logic              output_valid,
  output logic              busy
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int OXW  = width_of(IMG_W - WIN + 1);
  localparam int OYW  = width_of(IMG_H - WIN + 1);
  localparam int CW   = width_of(WIN);
  localparam int AW   = width_of(NPIX);

  localparam logic [OXW-1:0] OX_MAX = OXW'(IMG_W - WIN);
  localparam logic [OYW-1:0] OY_MAX = OYW'(IMG_H - WIN);
  localparam logic [OXW-1:0] OX_RST = OXW'((IMG_W - WIN) / 2);
  localparam logic [OYW-1:0] OY_RST = OYW'((IMG_H - WIN) / 2);
  localparam logic [CW-1:0]  C_LAST = CW'(WIN - 1);
  localparam logic [AW-1:0]  K_LAST = AW'(NPIX - 1);

  state_e            state, state_d;
  logic [OXW-1:0]    ox;
  logic [OYW-1:0]    oy;
  logic              mirror_h, mirror_v;
  logic [CW-1:0]     row, col;
  logic [AW-1:0]     ld_idx, rd_idx;
  logic [DATA_W-1:0] pix_buf [NPIX];
  logic              accept, ld_last, out_last;

  assign busy     = (state != IDLE);
  assign accept   = (state == IDLE) && cmd_valid;
  assign ld_last  = (ld_idx == K_LAST);
  assign out_last = (row == C_LAST) && (col == C_LAST);

  lcd_win_addr #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(WIN),
    .OXW(OXW), .OYW(OYW), .CW(CW), .AW(AW)
  ) u_addr (
    .ox(ox), .oy(oy), .row(row), .col(col),
    .mirror_h(mirror_h), .mirror_v(mirror_v), .idx(rd_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = (cmd_e'(cmd) == CMD_LOAD) ? LOAD : OUT;
      LOAD:    if (ld_last) state_d = OUT;
      OUT:     if (out_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ox           <= OX_RST;
      oy           <= OY_RST;
      mirror_h     <= 1'b0;
      mirror_v     <= 1'b0;
      row          <= '0;
      col          <= '0;
      ld_idx       <= '0;
      dataout      <= '0;
      output_valid <= 1'b0;
    end else begin
      output_valid <= (state == OUT);
      if (state == OUT) dataout <= pix_buf[rd_idx];
      case (state)
        IDLE: if (accept) begin
          row    <= '0;
          col    <= '0;
          ld_idx <= '0;
          case (cmd_e'(cmd))
            CMD_REFRESH:  ;
            CMD_LOAD: begin
              ox       <= OX_RST;
              oy       <= OY_RST;
              mirror_h <= 1'b0;
              mirror_v <= 1'b0;
            end
            CMD_RIGHT:    if (ox != OX_MAX) ox <= ox + 1'b1;
            CMD_LEFT:     if (ox != '0)     ox <= ox - 1'b1;
            CMD_UP:       if (oy != '0)     oy <= oy - 1'b1;
            CMD_DOWN:     if (oy != OY_MAX) oy <= oy + 1'b1;
            CMD_MIRROR_H: mirror_h <= ~mirror_h;
            CMD_MIRROR_V: mirror_v <= ~mirror_v;
          endcase
        end
        LOAD: ld_idx <= ld_idx + 1'b1;
        OUT: begin
          if (col == C_LAST) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NPIX; i++) pix_buf[i] <= '0;
    end else if (state == LOAD) begin
      pix_buf[ld_idx] <= datain;
    end
  end

endmodule

// File: tb/tb_lcd_win_ctrl.sv
// Scoreboard bench for lcd_win_ctrl: a high-level image/window model queues the
// expected pixels per command, independent monitors pop and compare them.
module tb_lcd_win_ctrl;

  localparam int IW = 8;
  localparam int IH = 8;
  localparam int W  = 3;
  localparam int NP = IW * IH;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] datain;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic [7:0] dataout;
  logic       output_valid;
  logic       busy;

  logic       s_reset = 1'b0;
  logic [7:0] s_datain;
  logic [2:0] s_cmd;
  logic       s_cmd_valid;
  logic [7:0] s_dataout;
  logic       s_output_valid;
  logic       s_busy;

  always #5 clk = ~clk;

  lcd_win_ctrl #(.DATA_W(8), .IMG_W(IW), .IMG_H(IH), .WIN(W)) dut (
    .clk(clk), .reset(reset), .datain(datain), .cmd(cmd), .cmd_valid(cmd_valid),
    .dataout(dataout), .output_valid(output_valid), .busy(busy)
  );

  lcd_win_ctrl #(.DATA_W(8), .IMG_W(5), .IMG_H(4), .WIN(2)) dut_small (
    .clk(clk), .reset(s_reset), .datain(s_datain), .cmd(s_cmd), .cmd_valid(s_cmd_valid),
    .dataout(s_dataout), .output_valid(s_output_valid), .busy(s_busy)
  );

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int exp2_q[$];
  int img[NP];
  int pix[NP];
  int m_ox, m_oy;
  bit m_mh, m_mv;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic void model_reset();
    m_ox = (IW - W) / 2;
    m_oy = (IH - W) / 2;
    m_mh = 0;
    m_mv = 0;
    foreach (img[i]) img[i] = 0;
  endfunction

  // Expected window pass: image pixel at (origin + possibly mirrored offset).
  function automatic void push_window();
    for (int r = 0; r < W; r++)
      for (int c = 0; c < W; c++) begin
        int sx, sy;
        sx = m_ox + (m_mh ? W - 1 - c : c);
        sy = m_oy + (m_mv ? W - 1 - r : r);
        exp_q.push_back(img[sy * IW + sx]);
      end
  endfunction

  function automatic void model_cmd(input int c);
    case (c)
      1: begin
        m_ox = (IW - W) / 2;
        m_oy = (IH - W) / 2;
        m_mh = 0;
        m_mv = 0;
        img = pix;
      end
      2: if (m_ox < IW - W) m_ox++;
      3: if (m_ox > 0) m_ox--;
      4: if (m_oy > 0) m_oy--;
      5: if (m_oy < IH - W) m_oy++;
      6: m_mh = !m_mh;
      7: m_mv = !m_mv;
      default: ;
    endcase
    push_window();
  endfunction

  always @(negedge clk) begin
    if (output_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pixel actual=%0d required=none", dataout);
      end else begin
        int e;
        e = exp_q.pop_front();
        check("pixel", int'(dataout), e);
      end
    end
  end

  always @(negedge clk) begin
    if (s_output_valid === 1'b1) begin
      if (exp2_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_small_pixel actual=%0d required=none", s_dataout);
      end else begin
        int e;
        e = exp2_q.pop_front();
        check("small_pixel", int'(s_dataout), e);
      end
    end
  end

  // Issue one command and time its pass. abort_k >= 0 asserts reset just
  // before load pixel abort_k would be sampled; ign pulses a stray command mid-pass.
  task automatic run_cmd(input int c, input int abort_k, input bit ign);
    int first, last, cnt, fall, n_load, waited;
    n_load = (c == 1) ? NP : 0;
    waited = 0;
    while (busy !== 1'b0 && waited < 200) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (busy !== 1'b0) begin
      $display("FAIL idle_timeout actual=busy required=idle");
      $fatal(1, "controller never returned to idle");
    end
    cmd       = 3'(c);
    cmd_valid = 1'b1;
    if (abort_k < 0) model_cmd(c);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    first = -1;
    last  = -1;
    cnt   = 0;
    fall  = -1;
    for (int e = 1; e <= NP + W * W + 10; e++) begin
      if (n_load != 0 && e <= NP) datain = 8'(pix[e - 1]);
      if (abort_k >= 0 && e == abort_k + 1) begin
        reset = 1'b1;
        #1;
        check("abort_dataout", int'(dataout), 0);
        check("abort_valid", int'(output_valid), 0);
        check("abort_busy", int'(busy), 0);
        model_reset();
        exp_q.delete();
        #3;
        reset = 1'b0;
        return;
      end
      cmd_valid = ign && (e == 3);
      if (ign && e == 3) cmd = 3'd2;
      @(posedge clk);
      #1;
      if (output_valid === 1'b1) begin
        if (first < 0) first = e;
        last = e;
        cnt++;
      end
      if (busy === 1'b0) begin
        fall = e;
        break;
      end
    end
    cmd_valid = 1'b0;
    check("first_valid", first, n_load + 1);
    check("last_valid", last, n_load + W * W);
    check("valid_count", cnt, W * W);
    check("busy_fall", fall, n_load + W * W + 1);
  endtask

  task automatic run_small(input int c);
    int fall;
    s_cmd       = 3'(c);
    s_cmd_valid = 1'b1;
    for (int k = 0; k < 4; k++) exp2_q.push_back((k / 2 + 1) * 5 + (k % 2 + 1));
    @(posedge clk);
    #1;
    s_cmd_valid = 1'b0;
    fall = -1;
    for (int e = 1; e <= 40; e++) begin
      if (c == 1 && e <= 20) s_datain = 8'(e - 1);
      @(posedge clk);
      #1;
      if (s_busy === 1'b0) begin
        fall = e;
        break;
      end
    end
    check("small_busy_fall", fall, (c == 1 ? 20 : 0) + 5);
  endtask

  initial begin
    cmd = 3'd0;
    cmd_valid = 1'b0;
    datain = 8'd0;
    s_cmd = 3'd0;
    s_cmd_valid = 1'b0;
    s_datain = 8'd0;
    #1;
    reset = 1'b1;
    s_reset = 1'b1;
    model_reset();
    #2;
    check("reset_dataout", int'(dataout), 0);
    check("reset_valid", int'(output_valid), 0);
    check("reset_busy", int'(busy), 0);
    check("small_reset_busy", int'(s_busy), 0);
    @(negedge clk);
    reset = 1'b0;
    s_reset = 1'b0;
    @(posedge clk);
    #1;

    for (int k = 0; k < NP; k++) pix[k] = k;
    run_cmd(1, -1, 0);
    repeat (4) run_cmd(2, -1, 0);
    repeat (5) run_cmd(3, -1, 0);
    repeat (3) run_cmd(4, -1, 0);
    repeat (2) run_cmd(2, -1, 0);
    repeat (2) run_cmd(5, -1, 0);
    run_cmd(6, -1, 0);
    run_cmd(7, -1, 0);
    run_cmd(1, -1, 0);
    run_cmd(0, -1, 1);
    run_cmd(2, -1, 1);
    run_cmd(1, 30, 0);
    run_cmd(0, -1, 0);

    for (int i = 0; i < 40; i++) begin
      int c;
      c = int'($urandom_range(0, 7));
      if (c == 1) foreach (pix[k]) pix[k] = int'($urandom_range(0, 255));
      run_cmd(c, -1, $urandom_range(0, 3) == 0);
    end

    run_small(1);
    run_small(0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    check("small_queue_drained", exp2_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
